// File: rtl/dehaze_pkg.sv
// Shared types and defaults for the dehaze pixel pipeline.
package dehaze_pkg;

  localparam int unsigned IMG_W_DEF = 512;
  localparam int unsigned IMG_H_DEF = 512;
  localparam int unsigned PIX_W     = 24;
  localparam int unsigned WIN_CNT_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } frame_state_t;

endpackage

// File: rtl/linebuf_frame_ctrl_if.sv
// Pixel ingress and window-generator egress signals of the frame sequencer.
interface linebuf_frame_ctrl_if;
  import dehaze_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_ready;
  logic             bank_rst;
  logic [PIX_W-1:0] bank_pixel;
  logic             bank_valid;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, bank_rst, bank_pixel, bank_valid
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, bank_rst, bank_pixel, bank_valid
  );

endinterface

// File: rtl/frame_pos_counter.sv
// Raster position tracker: column/row of the last advanced pixel plus a
// pixel count that saturates on the final pixel of the frame.
module frame_pos_counter #(
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512,
  localparam int unsigned CW  = $clog2(IMG_W),
  localparam int unsigned RW  = $clog2(IMG_H),
  localparam int unsigned PCW = $clog2(IMG_W * IMG_H)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_adv,
  output logic [CW-1:0]  o_col,
  output logic [RW-1:0]  o_row,
  output logic [PCW-1:0] o_pix_cnt
);

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(IMG_W * IMG_H - 1);

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [PCW-1:0] r_pix_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_pix_cnt <= '0;
    end else if (i_clr) begin
      r_col     <= '0;
      r_row     <= '0;
      r_pix_cnt <= '0;
    end else if (i_adv) begin
      if (r_pix_cnt != PIX_LAST) r_pix_cnt <= r_pix_cnt + PCW'(1);
      // The first pixel lands on (0,0); later pixels step from the previous one.
      if (r_pix_cnt != '0) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign o_col     = r_col;
  assign o_row     = r_row;
  assign o_pix_cnt = r_pix_cnt;

endmodule

// File: rtl/linebuf_frame_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window generator: primes, streams
// and zero-drains one frame, then raises a sticky done interrupt.
module linebuf_frame_ctrl
  import dehaze_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned PRIME_ROWS = 3,
  parameter int unsigned DRAIN_ROWS = 2
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     irq,
  input  logic                     irq_clr,
  linebuf_frame_ctrl_if.master     bus,
  output logic [$clog2(IMG_H)-1:0] row_idx,
  output logic [$clog2(IMG_W)-1:0] col_idx,
  output logic [WIN_CNT_W-1:0]     win_count
);

  localparam int unsigned PCW = $clog2(IMG_W * IMG_H);
  localparam int unsigned DCW = $clog2(DRAIN_ROWS * IMG_W + 1);
  localparam logic [PCW-1:0] PRIME_LAST = PCW'(PRIME_ROWS * IMG_W - 1);
  localparam logic [PCW-1:0] PIX_LAST   = PCW'(IMG_W * IMG_H - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_ROWS * IMG_W - 1);

  frame_state_t         r_state;
  frame_state_t         w_state_nxt;
  logic                 w_s_ready;
  logic                 w_start_go;
  logic                 w_win_inc;
  logic                 w_drain_beat;
  logic                 w_irq_set;
  logic                 w_accept;
  logic [PCW-1:0]       w_pix_cnt;
  logic [DCW-1:0]       r_drain_cnt;
  logic                 r_bank_rst;
  logic                 r_bank_valid;
  logic [PIX_W-1:0]     r_bank_pixel;
  logic                 r_irq;
  logic [WIN_CNT_W-1:0] r_win_count;

  frame_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk       (r_clk),
    .rst       (r_rst),
    .i_clr     (w_start_go),
    .i_adv     (w_accept),
    .o_col     (col_idx),
    .o_row     (row_idx),
    .o_pix_cnt (w_pix_cnt)
  );

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_PRIME;
      ST_PRIME:  if (w_accept && w_pix_cnt == PRIME_LAST) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_accept && w_pix_cnt == PIX_LAST) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_drain_beat && r_drain_cnt == DRAIN_LAST) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b1;
    w_s_ready    = 1'b0;
    w_start_go   = 1'b0;
    w_win_inc    = 1'b0;
    w_drain_beat = 1'b0;
    w_irq_set    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        w_start_go = start;
      end
      ST_PRIME:  w_s_ready = 1'b1;
      ST_STREAM: begin
        w_s_ready = bus.m_ready;
        w_win_inc = bus.m_ready & bus.s_valid;
      end
      ST_DRAIN: begin
        w_drain_beat = bus.m_ready;
        w_win_inc    = bus.m_ready;
      end
      ST_DONE:   w_irq_set = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  assign w_accept = bus.s_valid & w_s_ready;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_bank_rst   <= 1'b0;
      r_bank_valid <= 1'b0;
      r_bank_pixel <= '0;
      r_drain_cnt  <= '0;
      r_win_count  <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_bank_rst   <= w_start_go;
      r_bank_valid <= w_accept | w_drain_beat;
      if (w_accept)          r_bank_pixel <= bus.s_data;
      else if (w_drain_beat) r_bank_pixel <= '0;
      if (w_start_go) begin
        r_drain_cnt <= '0;
        r_win_count <= '0;
      end else begin
        if (w_drain_beat) r_drain_cnt <= r_drain_cnt + DCW'(1);
        if (w_win_inc)    r_win_count <= r_win_count + WIN_CNT_W'(1);
      end
      // A DONE-cycle set outranks a simultaneous clear.
      if (w_irq_set)    r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.bank_rst   = r_bank_rst;
  assign bus.bank_valid = r_bank_valid;
  assign bus.bank_pixel = r_bank_pixel;
  assign irq            = r_irq;
  assign win_count      = r_win_count;

endmodule

// File: tb/tb_linebuf_frame_ctrl.sv
// Directed and randomized stimulus for linebuf_frame_ctrl on an 8x8 frame,
// checked against a cycle-level reference model plus hand-computed totals.
`timescale 1ns/1ps
module tb_linebuf_frame_ctrl;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int PR     = 3;
  localparam int DR     = 2;
  localparam int NPIX   = W * H;    // 64
  localparam int NPRIME = PR * W;   // 24
  localparam int NDRAIN = DR * W;   // 16

  logic        r_clk   = 1'b0;
  logic        r_rst   = 1'b1;
  logic        start   = 1'b0;
  logic        irq_clr = 1'b0;
  logic        busy;
  logic        irq;
  logic [2:0]  row_idx;
  logic [2:0]  col_idx;
  logic [19:0] win_count;

  linebuf_frame_ctrl_if bus();

  linebuf_frame_ctrl #(
    .IMG_W      (W),
    .IMG_H      (H),
    .PRIME_ROWS (PR),
    .DRAIN_ROWS (DR)
  ) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .start     (start),
    .busy      (busy),
    .irq       (irq),
    .irq_clr   (irq_clr),
    .bus       (bus),
    .row_idx   (row_idx),
    .col_idx   (col_idx),
    .win_count (win_count)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 running (prime/stream/drain), 2 done.
  int          m_phase, m_nacc, m_ndrain, m_win, m_row, m_col;
  logic        m_bv, m_brst, m_irq;
  logic [23:0] m_px;
  int          obs_bv, obs_zero;
  int          k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_nacc = 0; m_ndrain = 0; m_win = 0; m_row = 0; m_col = 0;
    m_bv = 1'b0; m_brst = 1'b0; m_irq = 1'b0; m_px = '0;
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, advance the model.
  task automatic cycle(input int sv, input int d, input int mr, input int st, input int clr);
    logic sr;
    logic irq_n;
    bus.s_valid = (sv != 0);
    bus.s_data  = 24'(d);
    bus.m_ready = (mr != 0);
    start       = (st != 0);
    irq_clr     = (clr != 0);
    @(negedge r_clk);
    check("bank_rst", 32'(bus.bank_rst), 32'(m_brst));
    check("bank_valid", 32'(bus.bank_valid), 32'(m_bv));
    if (m_bv) check("bank_pixel", 32'(bus.bank_pixel), 32'(m_px));
    check("irq", 32'(irq), 32'(m_irq));
    check("win_count", 32'(win_count), m_win);
    check("row_idx", 32'(row_idx), m_row);
    check("col_idx", 32'(col_idx), m_col);
    sr = (m_phase == 1) && ((m_nacc < NPRIME) || ((m_nacc < NPIX) && (mr != 0)));
    check("s_ready", 32'(bus.s_ready), 32'(sr));
    check("busy", 32'(busy), 32'(m_phase != 0));
    if (bus.bank_valid) obs_bv++;
    if (bus.bank_valid && bus.bank_pixel == 24'd0) obs_zero++;
    irq_n  = (m_phase == 2) ? 1'b1 : ((clr != 0) ? 1'b0 : m_irq);
    m_brst = 1'b0;
    m_bv   = 1'b0;
    case (m_phase)
      0: if (st != 0) begin
        m_phase = 1; m_brst = 1'b1; m_nacc = 0; m_ndrain = 0;
        m_win = 0; m_row = 0; m_col = 0;
      end
      1: if ((sv != 0) && sr) begin
        m_bv = 1'b1; m_px = 24'(d); m_nacc++;
        m_row = (m_nacc - 1) / W; m_col = (m_nacc - 1) % W;
        if (m_nacc > NPRIME) m_win++;
      end else if (m_nacc == NPIX && mr != 0) begin
        m_bv = 1'b1; m_px = '0; m_win++; m_ndrain++;
        if (m_ndrain == NDRAIN) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    m_irq = irq_n;
    @(posedge r_clk);
    #1;
  endtask

  task automatic run_ready_frame();
    for (int c = 0; c < 500 && m_phase != 0; c++) begin
      cycle(1, k + 1, 1, 0, 0);
      k++;
    end
    check("frame_end_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    k = 0; obs_bv = 0; obs_zero = 0;
    model_reset();
    bus.s_valid = 1'b1; bus.s_data = 24'h123456; bus.m_ready = 1'b1;
    repeat (2) @(posedge r_clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_bank_valid", 32'(bus.bank_valid), 0);
    check("rst_bank_pixel", 32'(bus.bank_pixel), 0);
    check("rst_win", 32'(win_count), 0);
    r_rst = 1'b0;
    repeat (2) cycle(1, 7, 1, 0, 0);

    // Reset mid-PRIME discards the partial frame.
    cycle(0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin cycle(1, k + 1, 1, 0, 0); k++; end
    check("prime_row_pre", 32'(row_idx), 1);
    check("prime_col_pre", 32'(col_idx), 1);
    r_rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_s_ready", 32'(bus.s_ready), 0);
    check("midrst_row", 32'(row_idx), 0);
    check("midrst_col", 32'(col_idx), 0);
    check("midrst_win", 32'(win_count), 0);
    check("midrst_irq", 32'(irq), 0);
    check("midrst_bank_valid", 32'(bus.bank_valid), 0);
    @(posedge r_clk);
    #1;
    r_rst = 1'b0;
    model_reset();
    repeat (3) cycle(1, 9, 1, 0, 0);

    // Priming ignores backpressure; start while stalled in STREAM is ignored.
    obs_bv = 0; obs_zero = 0;
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, k + 1, 0, (i == 30) ? 1 : 0, 0);
      k++;
    end
    check("stall_beats", obs_bv, 24);
    check("stall_row", 32'(row_idx), 2);
    check("stall_col", 32'(col_idx), 7);
    check("stall_s_ready", 32'(bus.s_ready), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_win", 32'(win_count), 0);
    run_ready_frame();
    check("full_beats", obs_bv, 80);
    check("full_drain_zeros", obs_zero, 16);
    check("full_win", 32'(win_count), 56);
    check("full_irq", 32'(irq), 1);
    check("full_row", 32'(row_idx), 7);
    check("full_col", 32'(col_idx), 7);
    cycle(0, 0, 1, 0, 1);
    check("irq_cleared", 32'(irq), 0);
    cycle(0, 0, 1, 0, 1);
    check("irq_clr_idle", 32'(irq), 0);

    // Random stalls; irq_clr coincides with the DONE cycle.
    obs_bv = 0; obs_zero = 0;
    cycle(0, 0, 1, 1, 0);
    for (int c = 0; c < 3000 && m_phase != 0; c++) begin
      cycle(int'($urandom_range(1, 0)), int'(($urandom & 32'hFFFFFF) | 32'h1),
            int'($urandom_range(1, 0)), 0, (m_phase == 2) ? 1 : 0);
    end
    check("rand_busy", 32'(busy), 0);
    check("rand_irq_set_wins", 32'(irq), 1);
    check("rand_win", 32'(win_count), 56);
    check("rand_beats", obs_bv, 80);
    check("rand_drain_zeros", obs_zero, 16);

    // Back-to-back start on the first IDLE cycle, with irq_clr one cycle after DONE.
    cycle(0, 0, 1, 1, 1);
    check("b2b_bank_rst", 32'(bus.bank_rst), 1);
    check("b2b_irq", 32'(irq), 0);
    check("b2b_win", 32'(win_count), 0);
    check("b2b_row", 32'(row_idx), 0);
    check("b2b_col", 32'(col_idx), 0);
    check("b2b_busy", 32'(busy), 1);
    obs_bv = 0; obs_zero = 0;
    run_ready_frame();
    check("b2b_full_win", 32'(win_count), 56);
    check("b2b_drain_zeros", obs_zero, 16);
    check("b2b_irq_done", 32'(irq), 1);
    repeat (2) cycle(0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
